apb_cfg_responder: RTL

//  APB completer (responder) that terminates APB transfers issued by the uDMA config bus master.

---
 rtl/apb_cfg_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/apb_cfg_responder.sv
// APB completer for the uDMA config bus: clock-gate enable, read-only ID and RW config words,
// with programmable wait states and PSLVERR on bad accesses.
module apb_cfg_responder #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned N_REGS         = 16,
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter logic [31:0] ID_VALUE       = 32'h0000_0A9B
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [31:0]                 PWDATA,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [31:0]                 cg_en_o,
  output logic [32*(N_REGS-2)-1:0]    cfg_o,
  output logic [N_REGS-1:0]           wr_pulse_o
);

  localparam int unsigned IDX_W = APB_ADDR_WIDTH - 2;
  localparam int unsigned CFG_W = 32 * (N_REGS - 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                    state_r;
  logic [3:0]                cnt_r;
  logic [APB_ADDR_WIDTH-1:0] addr_r;
  logic                      write_r;
  logic [31:0]               wdata_r;
  logic [31:0]               cg_r;
  logic [CFG_W-1:0]          cfg_r;
  logic [N_REGS-1:0]         wr_pulse_r;

  logic [IDX_W-1:0]          idx_s;
  logic                      setup_s;
  logic                      ready_s;
  logic                      err_s;
  logic                      commit_s;
  logic [31:0]               rd_word_s;

  assign idx_s    = addr_r[APB_ADDR_WIDTH-1:2];
  assign setup_s  = PSEL & ~PENABLE;
  // Completion needs the live handshake as well as an expired wait counter.
  assign ready_s  = (state_r == ST_ACCESS) && (cnt_r == 4'd0) && PSEL && PENABLE;
  assign commit_s = ready_s & write_r & ~err_s;

  // Decode of the latched address: misaligned, out of range, or write to the ID word.
  always_comb begin
    err_s = 1'b0;
    if (addr_r[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else if (idx_s >= IDX_W'(N_REGS)) begin
      err_s = 1'b1;
    end else if (write_r && (idx_s == IDX_W'(1))) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Read mux over the register bank.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (idx_s)
      IDX_W'(0): rd_word_s = cg_r;
      IDX_W'(1): rd_word_s = ID_VALUE;
      default: begin
        rd_word_s = 32'h0000_0000;
        for (int i = 2; i < int'(N_REGS); i++) begin
          rd_word_s = rd_word_s | (cfg_r[(i-2)*32 +: 32] & {32{idx_s == IDX_W'(i)}});
        end
      end
    endcase
  end

  assign PREADY     = ready_s;
  assign PSLVERR    = ready_s & err_s;
  assign PRDATA     = (ready_s && !write_r && !err_s) ? rd_word_s : 32'h0000_0000;
  assign cg_en_o    = cg_r;
  assign cfg_o      = cfg_r;
  assign wr_pulse_o = wr_pulse_r;

  // Transfer FSM: setup latching, wait countdown, abort and back-to-back handling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {APB_ADDR_WIDTH{1'b0}};
      write_r <= 1'b0;
      wdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (setup_s) begin
            state_r <= ST_ACCESS;
            cnt_r   <= 4'(WAIT_CYCLES);
            addr_r  <= PADDR;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
          end else if ((state_r == ST_DONE) && PSEL) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_r <= ST_IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else if (PENABLE) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register bank: commit on the completing edge and raise the matching one-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cg_r       <= 32'h0000_0000;
      cfg_r      <= {CFG_W{1'b0}};
      wr_pulse_r <= {N_REGS{1'b0}};
    end else begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        wr_pulse_r[i] <= commit_s && (idx_s == IDX_W'(i));
      end
      if (commit_s && (idx_s == IDX_W'(0))) begin
        cg_r <= wdata_r;
      end
      for (int i = 2; i < int'(N_REGS); i++) begin
        if (commit_s && (idx_s == IDX_W'(i))) begin
          cfg_r[(i-2)*32 +: 32] <= wdata_r;
        end
      end
    end
  end

endmodule
